mcu_spi_tx_slave: RTL and testbench

- Downstream consumer of the Arduino-receive stage. Takes its registered sensor/status outputs (initialized, error, quat1_*, gyro1_*) and serves them to the MCU, which is the SPI master, as a fixed 16-byte frame.
- Runs entirely in the FPGA clk domain. The MCU's sck/cs_n/mosi are oversampled through synchronizers, so the block needs only one clock.
- The frame source is snapshotted when CS falls, so a frame is never torn by an upstream update.

---
 rtl/mcu_spi_tx_slave.sv | 150 +++++++++++++++
 tb/tb_mcu_spi_tx_slave.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_tx_slave.sv
// rtl/mcu_spi_tx_slave.sv - SPI mode-0 slave serving a 16-byte sensor/status frame to the MCU
// All SPI pins are oversampled in the clk domain; the frame is snapshotted on the CS fall.
module mcu_spi_tx_slave #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        initialized,
  input  logic        error,
  input  logic        quat1_valid,
  input  logic        gyro1_valid,
  input  logic [15:0] quat1_w,
  input  logic [15:0] quat1_x,
  input  logic [15:0] quat1_y,
  input  logic [15:0] quat1_z,
  input  logic [15:0] gyro1_x,
  input  logic [15:0] gyro1_y,
  input  logic [15:0] gyro1_z,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [7:0]  frame_count
);

  localparam logic [1:0] S_WAIT_IDLE = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_SHIFT     = 2'd2;
  localparam logic [7:0] ARM_LAST    = 8'(SYNC_STAGES);

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sck_prev_q;
  logic                   cs_s, sck_s;
  logic                   cs_fall, cs_rise, sck_rise, sck_fall;
  logic                   unused_mosi;

  logic [1:0]   state_q, state_d;
  logic [127:0] shift_q, shift_d;
  logic [7:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]   arm_cnt_q, arm_cnt_d;
  logic         done_q, done_d;
  logic         abort_q, abort_d;
  logic [7:0]   count_q, count_d;
  logic [127:0] frame_live;

  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign unused_mosi = mosi_sync_q[SYNC_STAGES-1];

  assign cs_fall  = cs_prev_q & ~cs_s;
  assign cs_rise  = ~cs_prev_q & cs_s;
  assign sck_rise = ~sck_prev_q & sck_s;
  assign sck_fall = sck_prev_q & ~sck_s;

  assign frame_live = {HEADER, 4'b0000, gyro1_valid, quat1_valid, error, initialized,
                       quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_prev_q   <= cs_s;
      sck_prev_q  <= sck_s;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    arm_cnt_d = arm_cnt_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    count_d   = count_q;
    case (state_q)
      S_WAIT_IDLE: begin
        // The synchronizer resets to "deselected", so CS high only counts once it has been flushed.
        if (!cs_s) begin
          arm_cnt_d = 8'd0;
        end else if (arm_cnt_q == ARM_LAST) begin
          arm_cnt_d = 8'd0;
          state_d   = S_IDLE;
        end else begin
          arm_cnt_d = arm_cnt_q + 8'd1;
        end
      end
      S_IDLE: begin
        if (cs_fall) begin
          shift_d   = frame_live;
          bit_cnt_d = 8'd0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          if (bit_cnt_q[7]) begin
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
          end else begin
            abort_d = 1'b1;
          end
        end else if (sck_rise) begin
          if (bit_cnt_q != 8'hFF) bit_cnt_d = bit_cnt_q + 8'd1;
        end else if (sck_fall && (bit_cnt_q != 8'd0)) begin
          shift_d = {shift_q[126:0], 1'b0};
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_WAIT_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= 8'd0;
      arm_cnt_q <= 8'd0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      arm_cnt_q <= arm_cnt_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      count_q   <= count_d;
    end
  end

  assign miso_oe     = (state_q == S_SHIFT);
  assign miso        = (state_q == S_SHIFT) & shift_q[127];
  assign frame_done  = done_q;
  assign frame_abort = abort_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_mcu_spi_tx_slave.sv
// tb/tb_mcu_spi_tx_slave.sv - scoreboard bench for mcu_spi_tx_slave
module tb_mcu_spi_tx_slave;

  logic        clk = 1'b0;
  logic        reset, sck, cs_n, mosi;
  logic        miso, miso_oe;
  logic        initialized, error, quat1_valid, gyro1_valid;
  logic [15:0] quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z;
  logic        frame_done, frame_abort;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_byte_q[$];
  logic [7:0] got_q[$];
  logic [8:0] exp_evt_q[$];
  logic [7:0] exp_count = 8'd0;

  logic [7:0] frame_a [16] = '{8'hA5, 8'h0D, 8'h40, 8'h00, 8'h12, 8'h34, 8'hFF, 8'h9C,
                               8'h00, 8'h01, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'hAA};
  logic [7:0] frame_z [16] = '{8'hA5, 8'h02, 8'h40, 8'h00, 8'hBE, 8'hEF, 8'hFF, 8'h9C,
                               8'h00, 8'h01, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'hAA};

  mcu_spi_tx_slave #(.HEADER(8'hA5), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .initialized(initialized), .error(error), .quat1_valid(quat1_valid), .gyro1_valid(gyro1_valid),
    .quat1_w(quat1_w), .quat1_x(quat1_x), .quat1_y(quat1_y), .quat1_z(quat1_z),
    .gyro1_x(gyro1_x), .gyro1_y(gyro1_y), .gyro1_z(gyro1_z),
    .frame_done(frame_done), .frame_abort(frame_abort), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic void push_model(input int nbytes);
    logic [127:0] f;
    f = {8'hA5, 4'b0000, gyro1_valid, quat1_valid, error, initialized,
         quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z};
    for (int i = 0; i < nbytes; i++)
      exp_byte_q.push_back((i < 16) ? f[127-8*i -: 8] : 8'h00);
  endfunction

  function automatic void push_done();
    exp_count = exp_count + 8'd1;
    exp_evt_q.push_back({1'b0, exp_count});
  endfunction

  // MCU master at clk/8: sample miso as sck rises, slave shifts on the fall.
  task automatic spi_read(input int nbits, input int chg_bit, input int rst_bit);
    logic [7:0] sh;
    bit         dead;
    sh   = 8'h00;
    dead = 1'b0;
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    if (rst_bit < 0) begin
      chk("cs_latency_oe", {31'd0, miso_oe}, 32'd1);
      chk("cs_latency_msb", {31'd0, miso}, 32'd1);
    end
    repeat (4) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      if (b == chg_bit) quat1_x = 16'hBEEF;
      if (b == rst_bit) begin
        #3 reset = 1'b1;
        #1;
        chk("reset_miso", {31'd0, miso}, 32'd0);
        chk("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("reset_count", {24'd0, frame_count}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        dead  = 1'b1;
      end
      if (dead) chk("post_reset_silent", {30'd0, miso_oe, miso}, 32'd0);
      mosi = 1'($urandom_range(0, 1));
      sh   = {sh[6:0], miso};
      sck  = 1'b1;
      repeat (4) @(negedge clk);
      sck  = 1'b0;
      repeat (4) @(negedge clk);
      if ((b % 8 == 7) && !dead) got_q.push_back(sh);
    end
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic fast_frame();
    cs_n = 1'b0;
    repeat (5) @(negedge clk);
    for (int b = 0; b < 128; b++) begin
      sck = 1'b1;
      @(negedge clk);
      sck = 1'b0;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Monitor: pops expected bytes/events as the MCU model and DUT produce them.
  initial begin
    logic [7:0] got, exp;
    logic [8:0] evt;
    int nbyte;
    nbyte = 0;
    forever begin
      @(negedge clk);
      while (got_q.size() > 0) begin
        got = got_q.pop_front();
        checks++;
        if (exp_byte_q.size() == 0) begin
          errors++;
          $display("FAIL miso_byte[%0d] got %02h expected none", nbyte, got);
        end else begin
          exp = exp_byte_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL miso_byte[%0d] got %02h expected %02h", nbyte, got, exp);
          end
        end
        nbyte++;
      end
      if (frame_done === 1'b1 || frame_abort === 1'b1) begin
        checks++;
        if (frame_done === 1'b1 && frame_abort === 1'b1) begin
          errors++;
          $display("FAIL frame_evt got done+abort expected one");
        end else if (exp_evt_q.size() == 0) begin
          errors++;
          $display("FAIL frame_evt got abort=%0b count=%0d expected none", frame_abort, frame_count);
        end else begin
          evt = exp_evt_q.pop_front();
          if ({frame_abort, frame_count} !== evt) begin
            errors++;
            $display("FAIL frame_evt got abort=%0b count=%0d expected abort=%0b count=%0d",
                     frame_abort, frame_count, evt[8], evt[7:0]);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
    initialized = 1'b1; error = 1'b0; quat1_valid = 1'b1; gyro1_valid = 1'b1;
    quat1_w = 16'h4000; quat1_x = 16'h1234; quat1_y = 16'hFF9C; quat1_z = 16'h0001;
    gyro1_x = 16'h8000; gyro1_y = 16'h7FFF; gyro1_z = 16'h00AA;
    repeat (3) @(negedge clk);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);
    chk("rst_abort", {31'd0, frame_abort}, 32'd0);
    chk("rst_count", {24'd0, frame_count}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 16; i++) exp_byte_q.push_back(frame_a[i]);
    push_done();
    spi_read(128, -1, -1);
    chk("count_after_first", {24'd0, frame_count}, 32'd1);

    push_model(16);
    push_done();
    spi_read(128, 32, -1);
    push_model(16);
    push_done();
    spi_read(128, -1, -1);

    push_model(5);
    exp_evt_q.push_back({1'b1, exp_count});
    spi_read(40, -1, -1);
    chk("count_after_abort", {24'd0, frame_count}, 32'd3);
    push_model(16);
    push_done();
    spi_read(128, -1, -1);

    push_model(20);
    push_done();
    spi_read(160, -1, -1);
    chk("count_after_long", {24'd0, frame_count}, 32'd5);

    push_model(5);
    spi_read(64, -1, 43);
    exp_count = 8'd0;
    chk("count_after_reset", {24'd0, frame_count}, 32'd0);
    push_model(16);
    push_done();
    spi_read(128, -1, -1);
    chk("count_restart", {24'd0, frame_count}, 32'd1);

    for (int n = 0; n < 298; n++) begin
      push_done();
      fast_frame();
    end

    initialized = 1'b0; error = 1'b1; quat1_valid = 1'b0; gyro1_valid = 1'b0;
    for (int i = 0; i < 16; i++) exp_byte_q.push_back(frame_z[i]);
    push_done();
    spi_read(128, -1, -1);
    chk("count_wrap", {24'd0, frame_count}, 32'd44);

    repeat (20) @(negedge clk);
    chk("bytes_drained", exp_byte_q.size(), 32'd0);
    chk("events_drained", exp_evt_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
